// File: rtl/crack_scheduler.sv
// crack_scheduler: sweeps RC4 keys 0..MAX_KEY across NUM_CORES crack cores
// and reports the smallest key whose core flagged a printable plaintext.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en / rdy        task start pulse (honoured while rdy=1) / idle flag
//   key, key_valid  smallest hitting key of the last sweep
//   core_en         per-core one-cycle start pulse
//   core_key        per-core key, slice i = core i, held until completion
//   core_rdy        per-core idle flag
//   core_hit        per-core result, sampled on the completion cycle
module crack_scheduler #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] MAX_KEY = {KEY_WIDTH{1'b1}}
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  output logic                           rdy,
  output logic [KEY_WIDTH-1:0]           key,
  output logic                           key_valid,
  output logic [NUM_CORES-1:0]           core_en,
  output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
  input  logic [NUM_CORES-1:0]           core_rdy,
  input  logic [NUM_CORES-1:0]           core_hit
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [1:0] C_IDLE   = 2'd0;
  localparam logic [1:0] C_LAUNCH = 2'd1;
  localparam logic [1:0] C_WLO    = 2'd2;
  localparam logic [1:0] C_WHI    = 2'd3;

  logic [1:0]           state_q, state_d;
  logic                 rdy_q, rdy_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic                 kv_q, kv_d;
  logic [KEY_WIDTH-1:0] cnt_q, cnt_d;
  logic                 exh_q, exh_d;
  logic [NUM_CORES-1:0] cen_q, cen_d;
  logic [1:0]           slot_q [NUM_CORES];
  logic [1:0]           slot_d [NUM_CORES];
  logic [KEY_WIDTH-1:0] ckey_q [NUM_CORES];
  logic [KEY_WIDTH-1:0] ckey_d [NUM_CORES];

  logic [NUM_CORES-1:0] done;
  logic [NUM_CORES-1:0] hit;
  logic                 hit_any;
  logic [KEY_WIDTH-1:0] hit_min;
  logic                 found;
  logic                 all_idle;

  // Completions this cycle and the min of their hits with the stored key.
  always_comb begin
    done    = '0;
    hit     = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      done[i] = (slot_q[i] == C_WHI) && core_rdy[i];
      hit[i]  = done[i] && core_hit[i];
    end
    hit_any = |hit;
    hit_min = kv_q ? key_q : '1;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (hit[i] && (ckey_q[i] < hit_min)) hit_min = ckey_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    rdy_d    = rdy_q;
    key_d    = key_q;
    kv_d     = kv_q;
    cnt_d    = cnt_q;
    exh_d    = exh_q;
    cen_d    = '0;
    found    = 1'b0;
    all_idle = 1'b1;
    slot_d   = slot_q;
    ckey_d   = ckey_q;

    for (int i = 0; i < NUM_CORES; i++) begin
      case (slot_q[i])
        C_LAUNCH: slot_d[i] = C_WLO;
        C_WLO:    if (!core_rdy[i]) slot_d[i] = C_WHI;
        C_WHI:    if (core_rdy[i]) slot_d[i] = C_IDLE;
        default:  slot_d[i] = slot_q[i];
      endcase
    end

    if (hit_any) begin
      key_d = hit_min;
      kv_d  = 1'b1;
    end

    // Issuing stops on the cycle the first hit is seen.
    if ((state_q == S_RUN) && !hit_any && !exh_q) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!found && (slot_q[i] == C_IDLE) && core_rdy[i]) begin
          found     = 1'b1;
          slot_d[i] = C_LAUNCH;
          cen_d[i]  = 1'b1;
          ckey_d[i] = cnt_q;
          if (cnt_q == MAX_KEY) exh_d = 1'b1;
          else cnt_d = cnt_q + KEY_WIDTH'(1);
        end
      end
    end

    for (int i = 0; i < NUM_CORES; i++) begin
      if (slot_d[i] != C_IDLE) all_idle = 1'b0;
    end

    // all_idle looks at next-state slots so rdy rises one cycle
    // after the last completion.
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_RUN;
          rdy_d   = 1'b0;
          kv_d    = 1'b0;
          key_d   = '0;
          cnt_d   = '0;
          exh_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (hit_any || exh_d) begin
          state_d = all_idle ? S_IDLE : S_DRAIN;
          rdy_d   = all_idle;
        end
      end
      S_DRAIN: begin
        if (all_idle) begin
          state_d = S_IDLE;
          rdy_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b1;
      key_q   <= '0;
      kv_q    <= 1'b0;
      cnt_q   <= '0;
      exh_q   <= 1'b0;
      cen_q   <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        slot_q[i] <= C_IDLE;
        ckey_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      key_q   <= key_d;
      kv_q    <= kv_d;
      cnt_q   <= cnt_d;
      exh_q   <= exh_d;
      cen_q   <= cen_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        slot_q[i] <= slot_d[i];
        ckey_q[i] <= ckey_d[i];
      end
    end
  end

  assign rdy       = rdy_q;
  assign key       = key_q;
  assign key_valid = kv_q;
  assign core_en   = cen_q;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_key
    assign core_key[g*KEY_WIDTH +: KEY_WIDTH] = ckey_q[g];
  end

endmodule

// File: tb/tb_crack_scheduler.sv
// tb_crack_scheduler: directed bench for crack_scheduler with two mock
// crack cores (fixed per-core latency, hit on a target key mask).
module tb_crack_scheduler;

  localparam int NC = 2;
  localparam int KW = 8;
  localparam logic [KW-1:0] MK = 8'd15;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          rdy;
  logic [KW-1:0] key;
  logic          key_valid;
  logic [NC-1:0] core_en;
  logic [NC*KW-1:0] core_key;
  logic [NC-1:0] core_rdy;
  logic [NC-1:0] core_hit;

  crack_scheduler #(
    .NUM_CORES(NC),
    .KEY_WIDTH(KW),
    .MAX_KEY(MK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .rdy(rdy),
    .key(key),
    .key_valid(key_valid),
    .core_en(core_en),
    .core_key(core_key),
    .core_rdy(core_rdy),
    .core_hit(core_hit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat [NC];
  logic [15:0] tmask;
  int mcnt [NC];
  logic [KW-1:0] mkey [NC];
  logic [NC-1:0] mprev = '1;
  int last_done = 0;
  int exp_next = 0;
  int disp_cnt [16];
  int disp_tot = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mock cores: rdy low the cycle after core_en, high again lat cycles on.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NC; i++) begin
      if (rst) begin
        core_rdy[i] <= 1'b1;
        mcnt[i]     <= 0;
        mkey[i]     <= '0;
      end else if (core_en[i]) begin
        core_rdy[i] <= 1'b0;
        mcnt[i]     <= lat[i];
        mkey[i]     <= core_key[i*KW +: KW];
      end else if (!core_rdy[i]) begin
        if (mcnt[i] == 1) core_rdy[i] <= 1'b1;
        else mcnt[i] <= mcnt[i] - 1;
      end
    end
  end

  always_comb begin
    core_hit = '0;
    for (int i = 0; i < NC; i++)
      core_hit[i] = core_rdy[i] && tmask[mkey[i][3:0]];
  end

  // Dispatch monitor: keys must be issued in strict order from 0.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NC; i++) begin
        if (core_en[i]) begin
          chk("dispatch_seq", 32'(core_key[i*KW +: KW]), 32'(exp_next));
          exp_next++;
          disp_tot++;
          if (core_key[i*KW +: KW] < 16)
            disp_cnt[core_key[i*KW +: 4]]++;
        end
        if (core_rdy[i] && !mprev[i]) last_done = cyc;
      end
    end
    mprev = core_rdy;
  end

  task automatic start();
    exp_next = 0;
    disp_tot = 0;
    for (int k = 0; k < 16; k++) disp_cnt[k] = 0;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wait_rdy(input string tag);
    int n;
    n = 0;
    while (!rdy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(rdy), 32'd1);
  endtask

  task automatic wait_kv(input string tag);
    int n;
    n = 0;
    while (!key_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(key_valid), 32'd1);
  endtask

  initial begin
    int ok;
    rst = 1'b1;
    en = 1'b0;
    lat[0] = 5;
    lat[1] = 5;
    tmask = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_kv", 32'(key_valid), 32'd0);
    chk("rst_key", 32'(key), 32'd0);
    chk("rst_cen", 32'(core_en), 32'd0);
    chk("rst_ckey", 32'(core_key), 32'd0);

    // 1) target 9, first dispatch latency and core key assignment
    tmask = 16'h0200;
    exp_next = 0;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("t1_rdy_low", 32'(rdy), 32'd0);
    chk("t1_cen_c1", 32'(core_en), 32'd0);
    @(negedge clk);
    chk("t1_cen_c2", 32'(core_en), 32'b01);
    chk("t1_key0", 32'(core_key[0 +: KW]), 32'd0);
    @(negedge clk);
    chk("t1_cen_c3", 32'(core_en), 32'b10);
    chk("t1_key1", 32'(core_key[KW +: KW]), 32'd1);
    wait_rdy("t1_done");
    chk("t1_key", 32'(key), 32'd9);
    chk("t1_kv", 32'(key_valid), 32'd1);

    // 2) no target: full sweep, each key once, rdy after last completion
    tmask = '0;
    start();
    wait_rdy("t2_done");
    chk("t2_rdy_lat", 32'(cyc), 32'(last_done + 1));
    chk("t2_kv", 32'(key_valid), 32'd0);
    chk("t2_total", 32'(disp_tot), 32'd16);
    ok = 1;
    for (int k = 0; k < 16; k++) if (disp_cnt[k] != 1) ok = 0;
    chk("t2_each_once", 32'(ok), 32'd1);
    chk("t2_cores_idle", 32'(core_rdy), 32'b11);
    repeat (4) @(negedge clk);
    chk("t2_no_more", 32'(disp_tot), 32'd16);

    // 3) slow core 0 holds key 0, fast core 1 hits key 3 first
    lat[0] = 20;
    lat[1] = 3;
    tmask = 16'h0009;
    start();
    wait_kv("t3_first_hit");
    chk("t3_key_first", 32'(key), 32'd3);
    chk("t3_draining", 32'(rdy), 32'd0);
    wait_rdy("t3_done");
    chk("t3_key_min", 32'(key), 32'd0);
    chk("t3_kv", 32'(key_valid), 32'd1);

    // 4) simultaneous completions hitting keys 2 and 3
    lat[0] = 6;
    lat[1] = 5;
    tmask = 16'h000C;
    start();
    wait_rdy("t4_done");
    chk("t4_key", 32'(key), 32'd2);
    chk("t4_kv", 32'(key_valid), 32'd1);

    // 5) en while busy is ignored; en after done restarts from 0
    lat[0] = 5;
    lat[1] = 5;
    tmask = 16'h0200;
    start();
    repeat (6) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("t5_busy", 32'(rdy), 32'd0);
    wait_rdy("t5_done");
    chk("t5_key", 32'(key), 32'd9);
    start();
    chk("t5_kv_clr", 32'(key_valid), 32'd0);
    chk("t5_rdy_low", 32'(rdy), 32'd0);
    wait_rdy("t5_done2");
    chk("t5_key2", 32'(key), 32'd9);

    // 6) reset mid-sweep after a hit has been recorded
    start();
    wait_kv("t6_hit");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rdy", 32'(rdy), 32'd1);
    chk("t6_kv", 32'(key_valid), 32'd0);
    chk("t6_key", 32'(key), 32'd0);
    chk("t6_cen", 32'(core_en), 32'd0);
    chk("t6_ckey", 32'(core_key), 32'd0);
    start();
    wait_rdy("t6_done");
    chk("t6_key_after", 32'(key), 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
